// File: rtl/inputbuffer_feeder.sv
// inputbuffer_feeder
// Frames a raw row-major pixel stream into one picture for the input buffer
// write port (sop, per-row hsync, start address) and issues the sram2reg
// line-pair requests that let the buffer fill its register array.
module inputbuffer_feeder #(
   parameter int dw = 128,
   parameter int aw = 10
) (
   input  logic          SYS_CLK,
   input  logic          SYS_RST,
   input  logic          cfg_start,
   input  logic [3:0]    cfg_mode,
   input  logic          cfg_padding,
   input  logic [5:0]    cfg_pic_size,
   input  logic [aw-1:0] cfg_addr_start,
   input  logic [dw-1:0] src_data,
   input  logic          src_valid,
   output logic          src_ready,
   output logic [dw-1:0] input_buffer_write_data,
   output logic          input_buffer_write_sop,
   output logic          input_buffer_write_hsync,
   output logic [aw-1:0] input_buffer_write_addr_start,
   output logic          input_buffer_write_valid,
   input  logic          input_buffer_write_ready,
   output logic          sram2reg_valid,
   input  logic          sram2reg_ready,
   output logic          busy,
   output logic          done
);

   typedef enum logic [2:0] {
      IDLE,
      SOP,
      STREAM,
      HSYNC,
      DRAIN,
      DONE
   } state_t;

   state_t          state;
   state_t          state_nx;

   logic            fc_mode_q;
   logic            padding_q;
   logic [5:0]      pic_size_q;
   logic [aw-1:0]   addr_start_q;

   logic [5:0]      row_cnt;
   logic [5:0]      col_cnt;
   logic [5:0]      req_cnt;

   logic            sop_q;
   logic            hsync_q;
   logic            busy_q;
   logic            done_q;
   logic            req_valid_q;

   logic            beat;
   logic            row_last;
   logic            req_hs;
   logic            in_frame;
   logic            req_valid_nx;
   logic [5:0]      req_total;
   logic [5:0]      req_cnt_nx;
   logic [7:0]      req_thresh;

   // Only the full-connected bit of the mode changes how a frame is framed.
   logic            unused_cfg_mode_bits;
   assign unused_cfg_mode_bits = ^cfg_mode[2:0];

   assign beat     = (state == STREAM) & src_valid & input_buffer_write_ready;
   assign row_last = (col_cnt == (pic_size_q - 6'd1));
   assign req_hs   = req_valid_q & sram2reg_ready;
   assign in_frame = (state == SOP) | (state == STREAM) | (state == HSYNC) | (state == DRAIN);

   // Request bookkeeping: how many line-pair requests this frame needs and
   // whether the next outstanding one has enough rows written to be issued.
   // The look-ahead on req_cnt keeps valid from re-asserting after the final
   // handshake; row_cnt only ever grows, so an asserted request never retracts.
   always_comb begin
      req_total  = fc_mode_q ? 6'd1 : ((pic_size_q >> 1) + {5'd0, padding_q});
      req_cnt_nx = req_cnt + {5'd0, req_hs};
      req_thresh = {1'b0, req_cnt_nx, 1'b0} + 8'd2;
      if (req_thresh > {2'b00, pic_size_q}) begin
         req_thresh = {2'b00, pic_size_q};
      end
      req_valid_nx = in_frame & (req_cnt_nx < req_total) & ({2'b00, row_cnt} >= req_thresh);
   end

   // Frame sequencing: sop, rows of beats separated by hsync, then drain the
   // remaining line-pair requests before signalling done.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (cfg_start) begin
               state_nx = (cfg_pic_size >= 6'd2) ? SOP : DONE;
            end
         end
         SOP: begin
            state_nx = STREAM;
         end
         STREAM: begin
            if (beat && row_last) begin
               state_nx = HSYNC;
            end
         end
         HSYNC: begin
            state_nx = (row_cnt == pic_size_q) ? DRAIN : STREAM;
         end
         DRAIN: begin
            if (req_cnt_nx == req_total) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State, registered outputs, latched configuration and counters. A reset
   // mid-frame simply returns everything to idle without a done pulse.
   always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
      if (SYS_RST) begin
         state        <= IDLE;
         sop_q        <= 1'b0;
         hsync_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         req_valid_q  <= 1'b0;
         fc_mode_q    <= 1'b0;
         padding_q    <= 1'b0;
         pic_size_q   <= 6'd0;
         addr_start_q <= '0;
         row_cnt      <= 6'd0;
         col_cnt      <= 6'd0;
         req_cnt      <= 6'd0;
      end else begin
         state       <= state_nx;
         sop_q       <= (state_nx == SOP);
         hsync_q     <= (state_nx == HSYNC);
         busy_q      <= (state_nx != IDLE);
         done_q      <= (state_nx == DONE);
         req_valid_q <= req_valid_nx;
         if (state == IDLE) begin
            if (cfg_start && (cfg_pic_size >= 6'd2)) begin
               fc_mode_q    <= cfg_mode[3];
               padding_q    <= cfg_padding;
               pic_size_q   <= cfg_pic_size;
               addr_start_q <= cfg_addr_start;
               row_cnt      <= 6'd0;
               col_cnt      <= 6'd0;
               req_cnt      <= 6'd0;
            end
         end else begin
            if (beat) begin
               if (row_last) begin
                  col_cnt <= 6'd0;
                  row_cnt <= row_cnt + 6'd1;
               end else begin
                  col_cnt <= col_cnt + 6'd1;
               end
            end
            req_cnt <= req_cnt_nx;
         end
      end
   end

   assign input_buffer_write_data       = src_data;
   assign input_buffer_write_valid      = (state == STREAM) & src_valid;
   assign src_ready                     = (state == STREAM) & input_buffer_write_ready;
   assign input_buffer_write_sop        = sop_q;
   assign input_buffer_write_hsync      = hsync_q;
   assign input_buffer_write_addr_start = addr_start_q;
   assign sram2reg_valid                = req_valid_q;
   assign busy                          = busy_q;
   assign done                          = done_q;

endmodule

// File: tb/tb_inputbuffer_feeder.sv
// tb_inputbuffer_feeder
// Directed frames against inputbuffer_feeder: nominal 4x4 and 6x6 frames,
// full-connected mode, random backpressure, degenerate picture size and a
// mid-frame reset. Expected cycle numbers are counted from the first cycle
// after the start pulse is sampled (t=0 is the sop cycle).
module tb_inputbuffer_feeder;

   logic         SYS_CLK;
   logic         SYS_RST;
   logic         cfg_start;
   logic [3:0]   cfg_mode;
   logic         cfg_padding;
   logic [5:0]   cfg_pic_size;
   logic [9:0]   cfg_addr_start;
   logic [127:0] src_data;
   logic         src_valid;
   logic         src_ready;
   logic [127:0] input_buffer_write_data;
   logic         input_buffer_write_sop;
   logic         input_buffer_write_hsync;
   logic [9:0]   input_buffer_write_addr_start;
   logic         input_buffer_write_valid;
   logic         input_buffer_write_ready;
   logic         sram2reg_valid;
   logic         sram2reg_ready;
   logic         busy;
   logic         done;

   int errors = 0;
   int checks = 0;

   int sop_count;
   int beat_count;
   int hsync_count;
   int hsync_err;
   int hsync2_at;
   int valid_first;
   int low_since_first;
   int low_at_last_hs;
   int req_hs_count;
   int last_hs_at;
   int done_at;
   int done_count;
   int prot_err;
   logic [9:0] addr_seen;
   logic [9:0] post_addr;
   logic       post_busy;
   logic       post_done;
   int         reset_bad;

   inputbuffer_feeder #(
      .dw(128),
      .aw(10)
   ) dut (
      .SYS_CLK                       (SYS_CLK),
      .SYS_RST                       (SYS_RST),
      .cfg_start                     (cfg_start),
      .cfg_mode                      (cfg_mode),
      .cfg_padding                   (cfg_padding),
      .cfg_pic_size                  (cfg_pic_size),
      .cfg_addr_start                (cfg_addr_start),
      .src_data                      (src_data),
      .src_valid                     (src_valid),
      .src_ready                     (src_ready),
      .input_buffer_write_data       (input_buffer_write_data),
      .input_buffer_write_sop        (input_buffer_write_sop),
      .input_buffer_write_hsync      (input_buffer_write_hsync),
      .input_buffer_write_addr_start (input_buffer_write_addr_start),
      .input_buffer_write_valid      (input_buffer_write_valid),
      .input_buffer_write_ready      (input_buffer_write_ready),
      .sram2reg_valid                (sram2reg_valid),
      .sram2reg_ready                (sram2reg_ready),
      .busy                          (busy),
      .done                          (done)
   );

   // Free-running 10 ns clock.
   initial SYS_CLK = 1'b0;
   always #5 SYS_CLK = ~SYS_CLK;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Runs one frame: pulses cfg_start, then drives the source/sink/request
   // handshakes each cycle and records what the DUT does. Inputs change on the
   // falling edge and outputs are sampled 1 ns later, so every handshake seen
   // here is the one the next rising edge will take.
   task automatic applyStimulus(input logic [5:0] pic, input logic pad, input logic [3:0] mode,
                                input logic [9:0] addr, input int v_pct, input int r_pct,
                                input int sr_mode, input int restart_at, input int abort_beats);
      int   total;
      int   src_idx;
      int   sink_idx;
      logic pend_hsync;
      logic prev_valid;
      logic prev_hs;
      logic in_stream;
      logic beat_now;
      logic hs_now;
      total = (pic >= 6'd2) ? int'(pic) * int'(pic) : 0;
      src_idx = 0;
      sink_idx = 0;
      pend_hsync = 1'b0;
      prev_valid = 1'b0;
      prev_hs = 1'b0;
      sop_count = 0;
      beat_count = 0;
      hsync_count = 0;
      hsync_err = 0;
      hsync2_at = -1;
      valid_first = -1;
      low_since_first = 0;
      low_at_last_hs = -1;
      req_hs_count = 0;
      last_hs_at = -1;
      done_at = -1;
      done_count = 0;
      prot_err = 0;
      @(negedge SYS_CLK);
      cfg_mode = mode;
      cfg_padding = pad;
      cfg_pic_size = pic;
      cfg_addr_start = addr;
      cfg_start = 1'b1;
      src_valid = 1'b0;
      input_buffer_write_ready = 1'b0;
      sram2reg_ready = 1'b0;
      @(negedge SYS_CLK);
      for (int t = 0; t < 400; t++) begin
         if (t > 0) @(negedge SYS_CLK);
         cfg_start = (t == restart_at);
         if (t == restart_at) begin
            cfg_pic_size = 6'd2;
            cfg_addr_start = 10'h3FF;
            cfg_mode = 4'd8;
         end
         src_valid = ($urandom_range(99) < v_pct);
         src_data = '0;
         src_data[31:0] = src_idx;
         input_buffer_write_ready = ($urandom_range(99) < r_pct);
         sram2reg_ready = (sr_mode == 0) ? 1'b1 : ((beat_count == total) && (t % 2 == 1));
         #1;
         in_stream = (total > 0) && (t > 0) && !pend_hsync && (beat_count < total);
         if (src_ready !== (in_stream & input_buffer_write_ready)) prot_err++;
         if (input_buffer_write_valid !== (in_stream & src_valid)) prot_err++;
         if (input_buffer_write_data !== src_data) prot_err++;
         if (input_buffer_write_sop !== ((total > 0) && (t == 0))) prot_err++;
         if (busy !== 1'b1) prot_err++;
         if (input_buffer_write_hsync !== pend_hsync) hsync_err++;
         if (input_buffer_write_sop === 1'b1) sop_count++;
         if (t == 0) addr_seen = input_buffer_write_addr_start;
         beat_now = input_buffer_write_valid & input_buffer_write_ready;
         pend_hsync = 1'b0;
         if (beat_now === 1'b1) begin
            if (input_buffer_write_data[31:0] !== sink_idx) prot_err++;
            sink_idx++;
            beat_count++;
            if (total > 0) pend_hsync = ((beat_count % int'(pic)) == 0);
         end
         if ((src_valid & src_ready) === 1'b1) src_idx++;
         if (input_buffer_write_hsync === 1'b1) begin
            hsync_count++;
            if (hsync_count == 2) hsync2_at = t;
         end
         hs_now = sram2reg_valid & sram2reg_ready;
         if (sram2reg_valid === 1'b1 && valid_first < 0) valid_first = t;
         if (valid_first >= 0 && sram2reg_valid !== 1'b1) low_since_first++;
         if (prev_valid && sram2reg_valid !== 1'b1 && !prev_hs) prot_err++;
         if (hs_now === 1'b1) begin
            req_hs_count++;
            last_hs_at = t;
            low_at_last_hs = low_since_first;
         end
         prev_valid = (sram2reg_valid === 1'b1);
         prev_hs = (hs_now === 1'b1);
         if (done === 1'b1) begin
            done_count++;
            done_at = t;
         end
         if (done === 1'b1) break;
         if (abort_beats > 0 && beat_count >= abort_beats) break;
      end
      @(negedge SYS_CLK);
      cfg_start = 1'b0;
      #1;
      post_busy = busy;
      post_done = done;
      post_addr = input_buffer_write_addr_start;
   endtask

   // Linear sequence of directed frames with hand-counted expectations.
   initial begin
      SYS_RST = 1'b1;
      cfg_start = 1'b0;
      cfg_mode = 4'd0;
      cfg_padding = 1'b0;
      cfg_pic_size = 6'd0;
      cfg_addr_start = 10'd0;
      src_data = '0;
      src_valid = 1'b1;
      input_buffer_write_ready = 1'b1;
      sram2reg_ready = 1'b1;
      @(negedge SYS_CLK);
      @(negedge SYS_CLK);
      #1;
      checkOutput("reset_outputs", {25'd0, input_buffer_write_sop, input_buffer_write_hsync,
                  input_buffer_write_valid, src_ready, sram2reg_valid, busy, done}, 32'd0);
      checkOutput("reset_addr", {22'd0, input_buffer_write_addr_start}, 32'd0);
      @(negedge SYS_CLK);
      SYS_RST = 1'b0;

      $display("[TB] 4x4 frame, always ready, late start pulse mid-frame");
      applyStimulus(6'd4, 1'b0, 4'd0, 10'h010, 100, 100, 0, 3, 0);
      checkOutput("a_sop_count", sop_count, 1);
      checkOutput("a_addr_start", {22'd0, addr_seen}, 32'h010);
      checkOutput("a_beats", beat_count, 16);
      checkOutput("a_hsync_count", hsync_count, 4);
      checkOutput("a_hsync_timing", hsync_err, 0);
      checkOutput("a_hsync2_at", hsync2_at, 10);
      checkOutput("a_valid_first", valid_first, 11);
      checkOutput("a_req_hs", req_hs_count, 2);
      checkOutput("a_last_hs", last_hs_at, 21);
      checkOutput("a_done_at", done_at, 22);
      checkOutput("a_protocol", prot_err, 0);
      checkOutput("a_post_idle", {30'd0, post_busy, post_done}, 32'd0);
      checkOutput("a_addr_kept", {22'd0, post_addr}, 32'h010);

      $display("[TB] 6x6 frame with padding, requests held off until streamed");
      applyStimulus(6'd6, 1'b1, 4'd0, 10'h020, 100, 100, 1, -1, 0);
      checkOutput("b_beats", beat_count, 36);
      checkOutput("b_hsync_count", hsync_count, 6);
      checkOutput("b_hsync_timing", hsync_err, 0);
      checkOutput("b_valid_first", valid_first, 15);
      checkOutput("b_valid_gaps", low_at_last_hs, 0);
      checkOutput("b_req_hs", req_hs_count, 4);
      checkOutput("b_last_hs", last_hs_at, 49);
      checkOutput("b_done_at", done_at, 50);
      checkOutput("b_protocol", prot_err, 0);

      $display("[TB] full-connected 4x4 frame");
      applyStimulus(6'd4, 1'b0, 4'd8, 10'h030, 100, 100, 0, -1, 0);
      checkOutput("c_beats", beat_count, 16);
      checkOutput("c_valid_first", valid_first, 11);
      checkOutput("c_req_hs", req_hs_count, 1);
      checkOutput("c_last_hs", last_hs_at, 11);
      checkOutput("c_done_at", done_at, 22);
      checkOutput("c_protocol", prot_err, 0);

      $display("[TB] 4x4 frame under random backpressure");
      applyStimulus(6'd4, 1'b0, 4'd0, 10'h040, 60, 60, 0, -1, 0);
      checkOutput("d_sop_count", sop_count, 1);
      checkOutput("d_beats", beat_count, 16);
      checkOutput("d_hsync_count", hsync_count, 4);
      checkOutput("d_hsync_timing", hsync_err, 0);
      checkOutput("d_req_hs", req_hs_count, 2);
      checkOutput("d_done_count", done_count, 1);
      checkOutput("d_protocol", prot_err, 0);

      $display("[TB] picture size 1, restart pulse while in DONE");
      applyStimulus(6'd1, 1'b0, 4'd0, 10'h050, 100, 100, 0, 0, 0);
      checkOutput("e_sop_count", sop_count, 0);
      checkOutput("e_beats", beat_count, 0);
      checkOutput("e_done_at", done_at, 0);
      checkOutput("e_protocol", prot_err, 0);
      checkOutput("e_post_idle", {30'd0, post_busy, post_done}, 32'd0);
      @(negedge SYS_CLK);
      #1;
      checkOutput("e_restart_ignored", {30'd0, busy, input_buffer_write_sop}, 32'd0);

      $display("[TB] reset after beat 5 of a 4x4 frame");
      applyStimulus(6'd4, 1'b0, 4'd0, 10'h060, 100, 100, 0, -1, 5);
      checkOutput("f_abort_beats", beat_count, 5);
      src_valid = 1'b1;
      input_buffer_write_ready = 1'b1;
      sram2reg_ready = 1'b1;
      SYS_RST = 1'b1;
      #1;
      checkOutput("f_reset_outputs", {25'd0, input_buffer_write_sop, input_buffer_write_hsync,
                  input_buffer_write_valid, src_ready, sram2reg_valid, busy, done}, 32'd0);
      checkOutput("f_reset_addr", {22'd0, input_buffer_write_addr_start}, 32'd0);
      reset_bad = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge SYS_CLK);
         #1;
         if (done !== 1'b0 || busy !== 1'b0 || src_ready !== 1'b0 || sram2reg_valid !== 1'b0) reset_bad++;
      end
      checkOutput("f_reset_held", reset_bad, 0);
      @(negedge SYS_CLK);
      SYS_RST = 1'b0;
      applyStimulus(6'd4, 1'b0, 4'd0, 10'h070, 100, 100, 0, -1, 0);
      checkOutput("f_clean_sop", sop_count, 1);
      checkOutput("f_clean_addr", {22'd0, addr_seen}, 32'h070);
      checkOutput("f_clean_beats", beat_count, 16);
      checkOutput("f_clean_req_hs", req_hs_count, 2);
      checkOutput("f_clean_done_at", done_at, 22);
      checkOutput("f_clean_protocol", prot_err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
